// File: rtl/mips_bus_lsu.sv
// mips_bus_lsu: arbitrates a fetch channel and a load/store channel onto one Avalon-MM master
//   in : clk, reset (async, active-high), if_req/if_addr, d_req/d_we/d_size/d_unsigned/d_addr/d_wdata,
//        waitrequest, readdata
//   out: if_ack/if_rdata/if_err, d_ack/d_err/d_rdata, address/writedata/read/write/byteenable, busy
module mips_bus_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [31:0]           if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_size,
  input  logic                  d_unsigned,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic [31:0]           d_rdata,
  output logic [31:0]           address,
  output logic [31:0]           writedata,
  output logic                  read,
  output logic                  write,
  output logic [3:0]            byteenable,
  input  logic                  waitrequest,
  input  logic [31:0]           readdata,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      r_state, w_state;
  logic        r_ch_d, w_ch_d, r_uns, w_uns;
  logic [1:0]  r_size, w_size;
  logic [31:0] r_addr, w_addr, r_stall, w_stall;
  logic        r_read, w_read, r_write, w_write;
  logic [31:0] r_address, w_address, r_wdata, w_wdata_o;
  logic [3:0]  r_be, w_be_o;
  logic        r_if_ack, w_if_ack, r_if_err, w_if_err, r_d_ack, w_d_ack, r_d_err, w_d_err;
  logic [31:0] r_if_rdata, w_if_rdata, r_d_rdata, w_d_rdata;
  logic [31:0] w_a, w_wd, w_lane, w_ld;
  logic [1:0]  w_sz;
  logic [3:0]  w_be;
  logic        w_we, w_mis, w_tmo;
  always_comb begin
    // data channel has priority; fetch is always a full word
    w_a    = d_req ? 32'(d_addr) : 32'(if_addr);
    w_sz   = d_req ? d_size : 2'b10;
    w_we   = d_req & d_we;
    w_mis  = (w_sz == 2'b01) ? w_a[0] : (w_sz[1] ? |w_a[1:0] : 1'b0);
    w_be   = (w_sz == 2'b00) ? 4'b0001 << w_a[1:0] : (w_sz == 2'b01) ? 4'b0011 << w_a[1:0] : 4'b1111;
    w_wd   = (w_sz == 2'b00) ? {4{d_wdata[7:0]}} : (w_sz == 2'b01) ? {2{d_wdata[15:0]}} : d_wdata;
    w_lane = readdata >> {r_addr[1:0], 3'b000};
    w_ld   = (r_size == 2'b00) ? {{24{~r_uns & w_lane[7]}}, w_lane[7:0]} :
             (r_size == 2'b01) ? {{16{~r_uns & w_lane[15]}}, w_lane[15:0]} : readdata;
    w_tmo  = (TIMEOUT != 0) && (r_stall + 32'd1 == 32'(TIMEOUT));
    w_state    = r_state;
    w_ch_d     = r_ch_d;
    w_uns      = r_uns;
    w_size     = r_size;
    w_addr     = r_addr;
    w_stall    = r_stall;
    w_read     = r_read;
    w_write    = r_write;
    w_address  = r_address;
    w_wdata_o  = r_wdata;
    w_be_o     = r_be;
    w_if_ack   = 1'b0;
    w_if_err   = 1'b0;
    w_if_rdata = '0;
    w_d_ack    = 1'b0;
    w_d_err    = 1'b0;
    w_d_rdata  = '0;
    if (r_state == IDLE && (d_req || if_req)) begin
      w_ch_d  = d_req;
      w_uns   = d_req & d_unsigned;
      w_size  = w_sz;
      w_addr  = w_a;
      w_stall = '0;
      if (w_mis) begin
        w_state  = RESP;
        w_d_ack  = d_req;
        w_d_err  = d_req;
        w_if_ack = ~d_req;
        w_if_err = ~d_req;
      end else begin
        w_state   = ACCESS;
        w_read    = ~w_we;
        w_write   = w_we;
        w_address = {w_a[31:2], 2'b00};
        w_wdata_o = w_we ? w_wd : '0;
        w_be_o    = w_be;
      end
    end else if (r_state == ACCESS) begin
      if (!waitrequest || w_tmo) begin
        w_state    = RESP;
        w_read     = 1'b0;
        w_write    = 1'b0;
        w_address  = '0;
        w_wdata_o  = '0;
        w_be_o     = '0;
        w_d_ack    = r_ch_d;
        w_d_err    = r_ch_d & waitrequest;
        w_d_rdata  = (r_ch_d && !waitrequest && r_read) ? w_ld : '0;
        w_if_ack   = ~r_ch_d;
        w_if_err   = ~r_ch_d & waitrequest;
        w_if_rdata = (!r_ch_d && !waitrequest) ? readdata : '0;
      end else begin
        w_stall = r_stall + 32'd1;
      end
    end else if (r_state == RESP) begin
      w_state = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ch_d     <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_stall    <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_address  <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_if_ack   <= 1'b0;
      r_if_err   <= 1'b0;
      r_if_rdata <= '0;
      r_d_ack    <= 1'b0;
      r_d_err    <= 1'b0;
      r_d_rdata  <= '0;
    end else begin
      r_state    <= w_state;
      r_ch_d     <= w_ch_d;
      r_uns      <= w_uns;
      r_size     <= w_size;
      r_addr     <= w_addr;
      r_stall    <= w_stall;
      r_read     <= w_read;
      r_write    <= w_write;
      r_address  <= w_address;
      r_wdata    <= w_wdata_o;
      r_be       <= w_be_o;
      r_if_ack   <= w_if_ack;
      r_if_err   <= w_if_err;
      r_if_rdata <= w_if_rdata;
      r_d_ack    <= w_d_ack;
      r_d_err    <= w_d_err;
      r_d_rdata  <= w_d_rdata;
    end
  end
  assign if_ack     = r_if_ack;
  assign if_err     = r_if_err;
  assign if_rdata   = r_if_rdata;
  assign d_ack      = r_d_ack;
  assign d_err      = r_d_err;
  assign d_rdata    = r_d_rdata;
  assign address    = r_address;
  assign writedata  = r_wdata;
  assign read       = r_read;
  assign write      = r_write;
  assign byteenable = r_be;
  assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_mips_bus_lsu.sv
// tb_mips_bus_lsu: directed self-checking bench for mips_bus_lsu
module tb_mips_bus_lsu;
  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 0, d_req = 0, d_we = 0, d_unsigned = 0, waitrequest = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, readdata = 0;
  logic [1:0] d_size = 0;
  logic if_ack, if_err, d_ack, d_err, read, write, busy;
  logic [31:0] if_rdata, d_rdata, address, writedata;
  logic [3:0] byteenable;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mips_bus_lsu #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rdata(if_rdata), .if_err(if_err), .d_req(d_req), .d_we(d_we), .d_size(d_size),
    .d_unsigned(d_unsigned), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err),
    .d_rdata(d_rdata), .address(address), .writedata(writedata), .read(read), .write(write),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata), .busy(busy));
  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, read, write, if_ack, d_ack, byteenable} !== 9'd0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {busy, read, write, if_ack, d_ack, byteenable});
    end
    checks++;
    if ({address, writedata, d_rdata, if_rdata} !== 128'd0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {address, writedata, d_rdata, if_rdata});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_fetch();
    readdata = 32'h24020005; waitrequest = 0; if_req = 1; if_addr = 32'hBFC00000;
    @(negedge clk);
    if_req = 0;
    checks++;
    if ({read, write, busy} !== 3'b101) begin errors++; $display("FAIL fetch_rw got %b exp 101", {read, write, busy}); end
    checks++;
    if (address !== 32'hBFC00000) begin errors++; $display("FAIL fetch_addr got %h exp bfc00000", address); end
    checks++;
    if (byteenable !== 4'b1111) begin errors++; $display("FAIL fetch_be got %b exp 1111", byteenable); end
    @(negedge clk);
    checks++;
    if ({if_ack, if_err, d_ack, read} !== 4'b1000) begin errors++; $display("FAIL fetch_ack got %b exp 1000", {if_ack, if_err, d_ack, read}); end
    checks++;
    if (if_rdata !== 32'h24020005) begin errors++; $display("FAIL fetch_rdata got %h exp 24020005", if_rdata); end
    checks++;
    if (address !== 32'd0) begin errors++; $display("FAIL fetch_addr_idle got %h exp 0", address); end
    @(negedge clk);
    checks++;
    if ({if_ack, busy} !== 2'b00) begin errors++; $display("FAIL fetch_done got %b exp 00", {if_ack, busy}); end
  endtask
  task automatic test_load(input string nm, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                           input logic [31:0] rd, input logic [3:0] ebe, input logic [31:0] exp);
    readdata = rd; waitrequest = 0; d_req = 1; d_we = 0; d_size = sz; d_unsigned = uns; d_addr = a;
    @(negedge clk);
    d_req = 0;
    checks++;
    if ({read, byteenable} !== {1'b1, ebe}) begin errors++; $display("FAIL %s_be got %b exp %b", nm, {read, byteenable}, {1'b1, ebe}); end
    checks++;
    if (address !== {a[31:2], 2'b00}) begin errors++; $display("FAIL %s_addr got %h exp %h", nm, address, {a[31:2], 2'b00}); end
    @(negedge clk);
    checks++;
    if ({d_ack, d_err, if_ack} !== 3'b100) begin errors++; $display("FAIL %s_ack got %b exp 100", nm, {d_ack, d_err, if_ack}); end
    checks++;
    if (d_rdata !== exp) begin errors++; $display("FAIL %s_rdata got %h exp %h", nm, d_rdata, exp); end
    @(negedge clk);
    checks++;
    if ({d_ack, busy} !== 2'b00) begin errors++; $display("FAIL %s_done got %b exp 00", nm, {d_ack, busy}); end
  endtask
  task automatic test_store_half();
    int wcnt = 0, acks = 0, bad = 0;
    waitrequest = 1; d_req = 1; d_we = 1; d_size = 2'b01; d_unsigned = 0; d_addr = 32'h2002; d_wdata = 32'h0000ABCD;
    @(negedge clk);
    d_req = 0; d_we = 0;
    for (int i = 0; i < 8; i++) begin
      if (write) begin
        wcnt++;
        if (writedata !== 32'hABCDABCD || byteenable !== 4'b1100 || address !== 32'h2000 || read) bad++;
      end
      if (d_ack) begin
        acks++;
        if (d_rdata !== 32'd0 || d_err) bad++;
      end
      if (i == 3) waitrequest = 0;
      @(negedge clk);
    end
    checks++;
    if (wcnt != 4) begin errors++; $display("FAIL store_wcycles got %0d exp 4", wcnt); end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL store_acks got %0d exp 1", acks); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL store_fields got %0d bad exp 0", bad); end
  endtask
  task automatic test_misaligned();
    waitrequest = 0; d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h2001;
    @(negedge clk);
    d_req = 0;
    checks++;
    if ({d_ack, d_err, read, if_ack} !== 4'b1100) begin errors++; $display("FAIL mis_word got %b exp 1100", {d_ack, d_err, read, if_ack}); end
    @(negedge clk);
    checks++;
    if ({d_ack, d_err, read} !== 3'b000) begin errors++; $display("FAIL mis_word_done got %b exp 000", {d_ack, d_err, read}); end
    d_req = 1; d_size = 2'b01; d_addr = 32'h3003;
    @(negedge clk);
    d_req = 0;
    checks++;
    if ({d_ack, d_err, read} !== 3'b110) begin errors++; $display("FAIL mis_half got %b exp 110", {d_ack, d_err, read}); end
    @(negedge clk);
    if_req = 1; if_addr = 32'h0000_0102;
    @(negedge clk);
    if_req = 0;
    checks++;
    if ({if_ack, if_err, d_ack, read} !== 4'b1100) begin errors++; $display("FAIL mis_fetch got %b exp 1100", {if_ack, if_err, d_ack, read}); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back();
    int dcyc = -1, fcyc = -1, nd = 0, nf = 0, both = 0;
    logic [31:0] first_addr = 32'hFFFFFFFF, frd = 0;
    readdata = 32'h11223344; waitrequest = 0;
    d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h10; if_req = 1; if_addr = 32'h20;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      d_req = 0;
      if (read && first_addr == 32'hFFFFFFFF) first_addr = address;
      if (d_ack && if_ack) both++;
      if (d_ack) begin nd++; dcyc = i; end
      if (if_ack) begin nf++; fcyc = i; frd = if_rdata; if_req = 0; end
    end
    checks++;
    if (first_addr !== 32'h10) begin errors++; $display("FAIL b2b_first got %h exp 10", first_addr); end
    checks++;
    if (nd != 1 || nf != 1) begin errors++; $display("FAIL b2b_acks got %0d/%0d exp 1/1", nd, nf); end
    checks++;
    if (both != 0) begin errors++; $display("FAIL b2b_overlap got %0d exp 0", both); end
    checks++;
    if (!(dcyc >= 0 && fcyc > dcyc)) begin errors++; $display("FAIL b2b_order got d=%0d f=%0d exp d<f", dcyc, fcyc); end
    checks++;
    if (frd !== 32'h11223344) begin errors++; $display("FAIL b2b_fetch_rdata got %h exp 11223344", frd); end
  endtask
  task automatic test_timeout();
    int rcnt = 0, acks = 0, bad = 0;
    waitrequest = 1; readdata = 32'hDEADBEEF; d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h40;
    @(negedge clk);
    d_req = 0;
    for (int i = 0; i < 10; i++) begin
      if (read) rcnt++;
      if (d_ack) begin
        acks++;
        if (!d_err || d_rdata !== 32'd0) bad++;
      end
      @(negedge clk);
    end
    checks++;
    if (rcnt != 4) begin errors++; $display("FAIL tmo_rcycles got %0d exp 4", rcnt); end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL tmo_acks got %0d exp 1", acks); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL tmo_err got %0d bad exp 0", bad); end
  endtask
  task automatic test_reset_mid();
    int acks = 0;
    waitrequest = 1; d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h80;
    @(negedge clk);
    d_req = 0;
    checks++;
    if (read !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b exp 1", read); end
    #2 reset = 1;
    #1;
    checks++;
    if ({read, busy, byteenable} !== 6'd0) begin errors++; $display("FAIL rst_mid_drop got %b exp 0", {read, busy, byteenable}); end
    @(negedge clk);
    reset = 0; waitrequest = 0;
    for (int i = 0; i < 4; i++) begin
      if (d_ack || if_ack) acks++;
      @(negedge clk);
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL rst_mid_noack got %0d exp 0", acks); end
  endtask
  initial begin
    test_reset();
    test_fetch();
    test_load("lb_s", 2'b00, 1'b0, 32'h1003, 32'h80FFFFFF, 4'b1000, 32'hFFFFFF80);
    test_load("lb_u", 2'b00, 1'b1, 32'h1003, 32'h80FFFFFF, 4'b1000, 32'h00000080);
    test_load("lh_s", 2'b01, 1'b0, 32'h1002, 32'h80011234, 4'b1100, 32'hFFFF8001);
    test_load("lbu0", 2'b00, 1'b1, 32'h1000, 32'h80FFFF7E, 4'b0001, 32'h0000007E);
    test_load("lw",   2'b11, 1'b0, 32'h1004, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    test_store_half();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_bus_lsu.md
MIPS_BUS_LSU -- requirements
Module: mips_bus_lsu

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of channel addresses (8..32); zero-extended onto the 32-bit bus address.
REQ-002 Parameter TIMEOUT, default 255, max stalled bus cycles before abort; 0 disables the watchdog.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 if_req  in  1  fetch-channel request.
REQ-006 if_addr  in  ADDR_WIDTH  fetch word address.
REQ-007 if_ack  out  1  fetch completion strobe.
REQ-008 if_rdata  out  32  fetched word, valid while if_ack=1.
REQ-009 if_err  out  1  fetch error (misaligned or timeout), valid while if_ack=1.
REQ-010 d_req  in  1  data-channel request.
REQ-011 d_we  in  1  1=store, 0=load.
REQ-012 d_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-013 d_unsigned  in  1  zero-extend sub-word loads when 1.
REQ-014 d_addr  in  ADDR_WIDTH  byte address.
REQ-015 d_wdata  in  32  store data, right-justified.
REQ-016 d_ack, d_err  out  1 each  data completion strobe and error.
REQ-017 d_rdata  out  32  extended load result, valid while d_ack=1.
REQ-018 address, writedata  out  32 each; read, write  out  1 each; byteenable  out  4; waitrequest, readdata  in  1/32 -- Avalon-MM master.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; all outputs registered.
REQ-021 IDLE: on an edge with d_req=1 the data channel SHALL be granted; else with if_req=1 fetch granted; request fields latched at that edge; later input changes ignored until ack.
REQ-022 Misaligned grant (half with addr[0]=1; word or fetch with addr[1:0]!=0) SHALL go IDLE->RESP with err=1, no bus cycle.
REQ-023 ACCESS: read=!we or write=we, address={addr[31:2],2'b00}; address/byteenable/writedata held stable while waitrequest=1.
REQ-024 byteenable: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word/fetch 4'b1111; little-endian lanes.
REQ-025 writedata: byte replicated to all four lanes; half replicated to both halves; word unchanged.
REQ-026 Edge in ACCESS with waitrequest=0 SHALL capture readdata lane(s) selected by addr[1:0], extend per d_unsigned (fetch: raw word), go RESP.
REQ-027 RESP: exactly one cycle of ack on the granted channel only, with rdata/err; stores return rdata=0; then IDLE.
REQ-028 Minimum latency: grant edge N, bus cycle N..N+1, ack high in cycle after N+1; one idle cycle between transactions.
REQ-029 Stall counter counts ACCESS cycles with waitrequest=1; on reaching TIMEOUT (TIMEOUT>0) read/write drop, go RESP with err=1, rdata=0.
REQ-030 Simultaneous requests: data served first, fetch granted at the next IDLE edge if still requested.
REQ-031 Outside ACCESS read=write=0, byteenable=0, address=0, writedata=0.

Reset
REQ-032 Reset SHALL immediately force IDLE, all outputs 0, stall counter 0, latched fields 0.
REQ-033 Reset mid-ACCESS SHALL drop read/write asynchronously; the aborted request produces no ack.

Verification
REQ-034 Fetch 0xBFC00000, waitrequest=0, readdata 0x24020005 -> one read cycle address 0xBFC00000 byteenable 1111; next cycle if_ack=1, if_rdata=0x24020005, if_err=0.
REQ-035 Load byte 0x00001003, readdata 0x80FFFFFF -> byteenable 1000, d_rdata 0xFFFFFF80; repeat d_unsigned=1 -> 0x00000080.
REQ-036 Store half 0x00002002, d_wdata 0x0000ABCD, waitrequest high 3 cycles -> write high 4 cycles, writedata 0xABCDABCD, byteenable 1100, single d_ack, d_rdata 0.
REQ-037 Load word 0x00002001 -> read never asserted, d_ack=1 and d_err=1 the cycle after grant.
REQ-038 if_req and d_req on same edge -> data transaction and d_ack first, then fetch transaction and if_ack; never both acks in one cycle.
REQ-039 TIMEOUT=4, waitrequest stuck 1 -> read high exactly 4 cycles, then d_err=1 with d_ack; reset asserted mid-ACCESS -> read=0 same cycle, no ack.
